// File: rtl/softmax_ctrl_if.sv
// softmax_ctrl_if: bundles the score input, exp unit, divider and probability output handshakes.
interface softmax_ctrl_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUTPUTS = 10
);
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_OUTPUTS);
  localparam int IDX_WIDTH = NUM_OUTPUTS > 1 ? $clog2(NUM_OUTPUTS) : 1;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  exp_req;
  logic [DATA_WIDTH-1:0] exp_arg;
  logic                  exp_ack;
  logic [DATA_WIDTH-1:0] exp_result;
  logic                  div_start;
  logic [DATA_WIDTH-1:0] div_num;
  logic [SUM_WIDTH-1:0]  div_den;
  logic                  div_done;
  logic [DATA_WIDTH-1:0] div_quot;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_idx;
  logic                  out_last;
  logic                  busy;
  modport master (
    input  in_valid, in_data, exp_ack, exp_result, div_done, div_quot, out_ready,
    output in_ready, exp_req, exp_arg, div_start, div_num, div_den,
           out_valid, out_data, out_idx, out_last, busy
  );
  modport slave (
    output in_valid, in_data, exp_ack, exp_result, div_done, div_quot, out_ready,
    input  in_ready, exp_req, exp_arg, div_start, div_num, div_den,
           out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/softmax_ctrl.sv
// softmax_ctrl: buffers a score vector, sequences max-shifted exp requests through an external
// exp unit, then divides each exp by the exp sum on an external divider and streams the results.
module softmax_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUTPUTS = 10
) (
  input logic            clk,
  input logic            rst_n,
  softmax_ctrl_if.master bus_if
);
  localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_OUTPUTS);
  localparam int IDX_WIDTH = NUM_OUTPUTS > 1 ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, EXP_REQ, EXP_WAIT, DIV_REQ, DIV_WAIT, OUT} state_e;

  state_e                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic [SUM_WIDTH-1:0]    sum_q, sum_d;
  logic                    exp_req_q, exp_req_d;
  logic                    div_start_q, div_start_d;
  logic [DATA_WIDTH-1:0]   exp_arg_q, exp_arg_d;
  logic [DATA_WIDTH-1:0]   div_num_q, div_num_d;
  logic [SUM_WIDTH-1:0]    div_den_q, div_den_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0]   score_q [NUM_OUTPUTS];
  logic [DATA_WIDTH-1:0]   exp_q [NUM_OUTPUTS];
  logic                    in_fire, ack_fire, cnt_last;
  logic [DATA_WIDTH:0]     diff;

  assign bus_if.in_ready  = state_q == IDLE || state_q == LOAD;
  assign in_fire          = bus_if.in_valid && bus_if.in_ready;
  assign ack_fire         = state_q == EXP_WAIT && bus_if.exp_ack;
  assign cnt_last         = cnt_q == LAST;
  // one extra bit so the most-negative minus the most-positive score is detectable
  assign diff = {score_q[cnt_q][DATA_WIDTH-1], score_q[cnt_q]} - {max_q[DATA_WIDTH-1], max_q};

  assign bus_if.exp_req   = exp_req_q;
  assign bus_if.exp_arg   = exp_arg_q;
  assign bus_if.div_start = div_start_q;
  assign bus_if.div_num   = div_num_q;
  assign bus_if.div_den   = div_den_q;
  assign bus_if.out_valid = state_q == OUT;
  assign bus_if.out_data  = out_data_q;
  assign bus_if.out_idx   = cnt_q;
  assign bus_if.out_last  = state_q == OUT && cnt_last;
  assign bus_if.busy      = state_q != IDLE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    sum_d       = sum_q;
    exp_req_d   = 1'b0;
    div_start_d = 1'b0;
    exp_arg_d   = exp_arg_q;
    div_num_d   = div_num_q;
    div_den_d   = div_den_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE, LOAD: if (in_fire) begin
        max_d   = (cnt_q == '0 || $signed(bus_if.in_data) > max_q) ? $signed(bus_if.in_data) : max_q;
        cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
        sum_d   = cnt_last ? '0 : sum_q;
        state_d = cnt_last ? EXP_REQ : LOAD;
      end
      EXP_REQ: begin
        exp_req_d = 1'b1;
        exp_arg_d = (diff[DATA_WIDTH] && !diff[DATA_WIDTH-1]) ? MOST_NEG : diff[DATA_WIDTH-1:0];
        state_d   = EXP_WAIT;
      end
      EXP_WAIT: if (bus_if.exp_ack) begin
        sum_d   = sum_q + SUM_WIDTH'(bus_if.exp_result);
        cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
        state_d = cnt_last ? DIV_REQ : EXP_REQ;
      end
      DIV_REQ: begin
        div_start_d = sum_q != '0;
        div_num_d   = sum_q != '0 ? exp_q[cnt_q] : div_num_q;
        div_den_d   = sum_q != '0 ? sum_q : div_den_q;
        out_data_d  = sum_q != '0 ? out_data_q : '0;
        state_d     = sum_q != '0 ? DIV_WAIT : OUT;
      end
      DIV_WAIT: if (bus_if.div_done) begin
        out_data_d = bus_if.div_quot;
        state_d    = OUT;
      end
      OUT: if (bus_if.out_ready) begin
        cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
        state_d = cnt_last ? IDLE : DIV_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      exp_req_q   <= 1'b0;
      div_start_q <= 1'b0;
      exp_arg_q   <= '0;
      div_num_q   <= '0;
      div_den_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      exp_req_q   <= exp_req_d;
      div_start_q <= div_start_d;
      exp_arg_q   <= exp_arg_d;
      div_num_q   <= div_num_d;
      div_den_q   <= div_den_d;
      out_data_q  <= out_data_d;
    end
  end

  // buffers carry no reset: their contents are rewritten before every use
  always_ff @(posedge clk) begin
    if (in_fire) score_q[cnt_q] <= bus_if.in_data;
    if (ack_fire) exp_q[cnt_q] <= bus_if.exp_result;
  end
endmodule

// File: tb/tb_softmax_ctrl.sv
// tb_softmax_ctrl: drives score vectors into softmax_ctrl with modelled exp/div units and
// compares every request and probability against a vector-level softmax reference.
module tb_softmax_ctrl;
  localparam int DW = 16;
  localparam int N  = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  softmax_ctrl_if #(.DATA_WIDTH(DW), .NUM_OUTPUTS(N)) bus_if ();
  softmax_ctrl #(.DATA_WIDTH(DW), .NUM_OUTPUTS(N)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus_if));

  int n_tests = 0;
  int n_fail  = 0;
  bit zero_mode = 1'b0;
  int lat_mode  = 0;
  int arg_q[$];
  longint num_q[$], den_q[$];
  logic rsp_ack, rsp_done, spur_ack, spur_done;
  logic [DW-1:0] rsp_res, rsp_quot;
  int ea, el, dl;
  longint dn, dd;

  assign bus_if.exp_ack    = rsp_ack | spur_ack;
  assign bus_if.exp_result = spur_ack ? 16'h1234 : rsp_res;
  assign bus_if.div_done   = rsp_done | spur_done;
  assign bus_if.div_quot   = spur_done ? 16'hBEEF : rsp_quot;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_fn(input int a);
    if (zero_mode || -a > 15) return '0;
    return 16'hFFFF >> (-a);
  endfunction

  function automatic int pick_lat();
    return lat_mode == 1 ? int'($urandom_range(1, 8)) : (lat_mode == 2 ? 8 : 1);
  endfunction

  initial begin
    rsp_ack = 1'b0;
    rsp_res = '0;
    forever begin
      @(negedge clk);
      if (bus_if.exp_req) begin
        ea = int'($signed(bus_if.exp_arg));
        arg_q.push_back(ea);
        el = pick_lat();
        repeat (el - 1) @(negedge clk);
        rsp_ack = 1'b1;
        rsp_res = exp_fn(ea);
        @(negedge clk);
        rsp_ack = 1'b0;
      end
    end
  end

  initial begin
    rsp_done = 1'b0;
    rsp_quot = '0;
    forever begin
      @(negedge clk);
      if (bus_if.div_start) begin
        dn = longint'(bus_if.div_num);
        dd = longint'(bus_if.div_den);
        num_q.push_back(dn);
        den_q.push_back(dd);
        dl = pick_lat();
        repeat (dl - 1) @(negedge clk);
        rsp_done = 1'b1;
        rsp_quot = DW'(dd == 0 ? 0 : dn * 65535 / dd);
        @(negedge clk);
        rsp_done = 1'b0;
      end
    end
  end

  task automatic load(input int sc[N]);
    chk("in_ready_idle", bus_if.in_ready, 1);
    for (int i = 0; i < N; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = DW'(sc[i]);
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    chk("busy_after_load", bus_if.busy, 1);
  endtask

  task automatic collect(input longint p[N], input int stall, input bit spur);
    for (int i = 0; i < N; i++) begin
      int n;
      logic [DW-1:0] d0;
      logic [3:0] i0;
      logic l0;
      bit stable;
      n = 0;
      while (!bus_if.out_valid && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("out_valid_wait", bus_if.out_valid, 1);
      d0 = bus_if.out_data;
      i0 = bus_if.out_idx;
      l0 = bus_if.out_last;
      stable = 1'b1;
      for (int s = 0; s < stall; s++) begin
        if (spur && s == 1) begin
          spur_ack  = 1'b1;
          spur_done = 1'b1;
        end
        @(negedge clk);
        spur_ack  = 1'b0;
        spur_done = 1'b0;
        if (!bus_if.out_valid || bus_if.out_data !== d0 || bus_if.out_idx !== i0 || bus_if.out_last !== l0)
          stable = 1'b0;
      end
      if (stall > 0) chk("stall_stable", stable, 1);
      chk("out_data", d0, p[i]);
      chk("out_idx", i0, i);
      chk("out_last", l0, i == N - 1);
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
    end
    chk("busy_after_last", bus_if.busy, 0);
  endtask

  task automatic run_vec(input int sc[N], input int stall, input bit spur);
    int mx;
    int args[N];
    longint e[N], p[N];
    longint sum;
    mx = sc[0];
    foreach (sc[i]) if (sc[i] > mx) mx = sc[i];
    sum = 0;
    for (int i = 0; i < N; i++) begin
      args[i] = sc[i] - mx < -32768 ? -32768 : sc[i] - mx;
      e[i] = longint'(exp_fn(args[i]));
      sum += e[i];
    end
    for (int i = 0; i < N; i++) p[i] = sum == 0 ? 0 : e[i] * 65535 / sum;
    arg_q.delete();
    num_q.delete();
    den_q.delete();
    load(sc);
    collect(p, stall, spur);
    chk("exp_req_count", arg_q.size(), N);
    for (int i = 0; i < arg_q.size() && i < N; i++) chk("exp_arg", arg_q[i], args[i]);
    chk("div_start_count", num_q.size(), sum == 0 ? 0 : N);
    for (int i = 0; i < num_q.size() && i < N; i++) begin
      chk("div_num", num_q[i], e[i]);
      chk("div_den", den_q[i], sum);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus_if.in_ready, 1);
    chk({tag, "_busy"}, bus_if.busy, 0);
    chk({tag, "_out_valid"}, bus_if.out_valid, 0);
    chk({tag, "_exp_req"}, bus_if.exp_req, 0);
    chk({tag, "_div_start"}, bus_if.div_start, 0);
    chk({tag, "_out_data"}, bus_if.out_data, 0);
    chk({tag, "_out_idx"}, bus_if.out_idx, 0);
    chk({tag, "_out_last"}, bus_if.out_last, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int sc[N];
    int n;
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    spur_ack  = 1'b0;
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) sc[i] = i;
    run_vec(sc, 0, 1'b0);
    for (int i = 0; i < N; i++) sc[i] = 5;
    run_vec(sc, 0, 1'b0);
    for (int i = 0; i < N; i++) sc[i] = i % 3 == 0 ? -32768 : 32767;
    run_vec(sc, 0, 1'b0);
    zero_mode = 1'b1;
    for (int i = 0; i < N; i++) sc[i] = int'($urandom_range(0, 40)) - 20;
    run_vec(sc, 0, 1'b0);
    zero_mode = 1'b0;

    lat_mode = 1;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < N; i++) sc[i] = int'($urandom_range(0, 40)) - 20;
      run_vec(sc, 5, 1'b1);
    end
    for (int i = 0; i < N; i++) sc[i] = int'($signed(DW'($urandom)));
    run_vec(sc, 2, 1'b1);

    // abandon a vector while element 4 waits on a slow exp unit
    lat_mode = 2;
    arg_q.delete();
    for (int i = 0; i < N; i++) sc[i] = int'($urandom_range(0, 30)) - 15;
    load(sc);
    n = 0;
    while (arg_q.size() < 5 && n < 400) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("reach_elem4", arg_q.size(), 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    lat_mode = 0;
    for (int i = 0; i < N; i++) sc[i] = int'($urandom_range(0, 40)) - 20;
    run_vec(sc, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/softmax_ctrl.md
SOFTMAX_CTRL -- requirements
Module: softmax_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of scores, exp results and probabilities.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 10, number of scores per softmax vector.
REQ-003 SHALL derive SUM_WIDTH = DATA_WIDTH + $clog2(NUM_OUTPUTS) and IDX_WIDTH = max(1, $clog2(NUM_OUTPUTS)).
REQ-004 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  score valid.
- in_ready  out  1  controller accepts a score.
- in_data  in  DATA_WIDTH  signed two's-complement score.
- exp_req  out  1  exp request to the external exp unit.
- exp_arg  out  DATA_WIDTH  signed argument, score minus vector max; always <= 0.
- exp_ack  in  1  one-cycle pulse; exp_result valid in the same cycle.
- exp_result  in  DATA_WIDTH  unsigned exp value.
- div_start  out  1  one-cycle divider start pulse.
- div_num  out  DATA_WIDTH  numerator: stored exp value.
- div_den  out  SUM_WIDTH  denominator: exp sum.
- div_done  in  1  one-cycle pulse; div_quot valid in the same cycle.
- div_quot  in  DATA_WIDTH  quotient.
- out_valid  out  1  probability valid.
- out_ready  in  1  downstream accepts the probability.
- out_data  out  DATA_WIDTH  probability.
- out_idx  out  IDX_WIDTH  index of the current element, 0..NUM_OUTPUTS-1.
- out_last  out  1  high with index NUM_OUTPUTS-1.
- busy  out  1  high in every state except IDLE.

Function
REQ-005 SHALL implement the states IDLE, LOAD, EXP_REQ, EXP_WAIT, DIV_REQ, DIV_WAIT and OUT.
REQ-006 IDLE -> LOAD SHALL occur on the first in_valid; the IDLE cycle with in_valid high counts as a LOAD transfer.
- in_ready SHALL be 1 only in IDLE and LOAD.
REQ-007 For each in_valid&&in_ready transfer, the controller SHALL write in_data to score buffer slot cnt and increment cnt.
- The signed running max SHALL be updated; it is reset to the first element of each vector.
- The transfer of element NUM_OUTPUTS-1 SHALL move the FSM to EXP_REQ with cnt=0 and sum=0.
REQ-008 In EXP_REQ, the controller SHALL assert exp_req with exp_arg = score[cnt] - max for exactly one cycle, then go to EXP_WAIT.
- The subtraction SHALL be computed at DATA_WIDTH+1 bits.
- A result below the minimum signed value SHALL saturate to the most negative value.
REQ-009 On exp_ack in EXP_WAIT, the controller SHALL store exp_result into exp buffer slot cnt and add it zero-extended to sum.
- After element NUM_OUTPUTS-1 the FSM SHALL go to DIV_REQ with cnt=0; otherwise it returns to EXP_REQ with cnt+1.
- exp_ack outside EXP_WAIT SHALL be ignored.
REQ-010 sum SHALL be SUM_WIDTH bits; it cannot overflow, and no wrap handling is needed.
REQ-011 In DIV_REQ with sum != 0, the controller SHALL pulse div_start for one cycle with div_num = exp[cnt] and div_den = sum, then go to DIV_WAIT.
- With sum == 0, it SHALL skip the divider, load out_data = 0 and go to OUT.
REQ-012 On div_done in DIV_WAIT, the controller SHALL register div_quot into out_data and go to OUT.
- div_done outside DIV_WAIT SHALL be ignored.
REQ-013 In OUT, out_valid SHALL be 1, out_idx = cnt and out_last = (cnt == NUM_OUTPUTS-1).
- out_data, out_idx and out_last SHALL hold stable until out_ready.
REQ-014 On out_valid&&out_ready, the FSM SHALL go to IDLE after the last element; otherwise it goes to DIV_REQ with cnt+1.
REQ-015 div_num, div_den and exp_arg SHALL be registered and hold their last values outside request cycles.
REQ-016 Latency from the final input transfer to the first out_valid SHALL be 2*NUM_OUTPUTS + 2 cycles plus the exp and divider latencies.
- This assumes zero-wait exp/div acks.

Reset
REQ-017 While rst_n = 0, the controller SHALL immediately force the state to IDLE.
- All of cnt, max, sum, exp_req, div_start, out_valid, out_data, out_idx, out_last and busy SHALL be 0.
- in_ready SHALL be 1.
- Buffer contents are don't-care.
REQ-018 Reset asserted mid-vector SHALL abandon the vector.
- A later exp_ack or div_done from the in-flight operation SHALL be ignored.

Verification
REQ-019 The bench SHALL cover these directed scenarios, one line each:
- Scores 0..9 (NUM_OUTPUTS=10), 1-cycle exp/div models -> exp_arg sequence -9..0; 10 outputs; idx 0..9; out_last only at idx 9; busy drops the cycle after the last handshake.
- All-equal scores 5 -> every exp_arg = 0; every div_den = 10*exp(0); all ten out_data identical.
- Scores -32768 and 32767 mixed -> exp_arg saturates to -32768 for -32768 - 32767.
- exp model returns 0 always -> sum = 0; div_start never pulses; ten outputs with out_data = 0.
- out_ready low 5 cycles per element, random exp/div latencies 1-8 -> no output changes while stalled; order preserved; spurious exp_ack/div_done ignored.
- rst_n pulsed low during EXP_WAIT of element 4 -> outputs reset asynchronously; the next vector completes correctly; the stale ack is ignored.
